// File: rtl/multi_region_atomicity.sv
// Atomicity monitor for up to four protected MSP430 code regions: entry only
// through an entry point, forward progress, exit only from the last address.
module multi_region_atomicity #(
  parameter int                        N_REGIONS     = 2,
  parameter logic [N_REGIONS*16-1:0]   REGION_BASE   = {16'hA000, 16'hE000},
  parameter logic [N_REGIONS*16-1:0]   REGION_SIZE   = {16'h0400, 16'h1000},
  parameter logic [N_REGIONS*16-1:0]   ALT_ENTRY     = {16'hA226, 16'h0000},
  parameter bit                        IRQ_CHECK     = 1'b1,
  parameter logic [15:0]               RESET_HANDLER = 16'hFFFE
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        pc_en,
  input  logic        irq,
  output logic        reset,
  output logic        in_region,
  output logic [1:0]  active_region,
  output logic [2:0]  viol_cause,
  output logic [1:0]  viol_region
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    MID   = 3'd2,
    LAST  = 3'd3,
    KILL  = 3'd4
  } state_t;

  localparam logic [2:0] CAUSE_ENTRY = 3'd1;
  localparam logic [2:0] CAUSE_EXIT  = 3'd2;
  localparam logic [2:0] CAUSE_ORDER = 3'd3;
  localparam logic [2:0] CAUSE_IRQ   = 3'd4;

  state_t state, next_state;

  logic [3:0] first_r, mid_r, last_r, inreg_r;
  logic [1:0] hit_idx;
  logic       any_inreg;
  logic [1:0] next_cur;
  logic       go_kill;
  logic [2:0] kill_cause;
  logic [1:0] kill_region;
  logic       first_cur, mid_cur, last_cur;

  // Per-region address decode; unused slots above N_REGIONS never match.
  for (genvar g = 0; g < 4; g++) begin : g_region
    if (g < N_REGIONS) begin : g_used
      localparam logic [15:0] BASE = REGION_BASE[16*g +: 16];
      localparam logic [15:0] SIZE = REGION_SIZE[16*g +: 16];
      localparam logic [15:0] ALT  = ALT_ENTRY[16*g +: 16];
      localparam logic [15:0] LADR = BASE + SIZE - 16'd2;
      assign first_r[g] = (pc == BASE) || ((ALT != 16'h0000) && (pc == ALT));
      assign last_r[g]  = (pc == LADR);
      assign mid_r[g]   = (pc > BASE) && (pc < LADR) && !first_r[g];
    end else begin : g_unused
      assign first_r[g] = 1'b0;
      assign last_r[g]  = 1'b0;
      assign mid_r[g]   = 1'b0;
    end
  end

  assign inreg_r   = first_r | mid_r | last_r;
  assign any_inreg = |inreg_r;

  // Lowest-index match wins if regions were ever configured to overlap.
  always_comb begin
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (inreg_r[i]) hit_idx = 2'(i);
    end
  end

  assign first_cur = first_r[active_region];
  assign mid_cur   = mid_r[active_region];
  assign last_cur  = last_r[active_region];

  always_comb begin
    next_state  = state;
    next_cur    = active_region;
    go_kill     = 1'b0;
    kill_cause  = 3'd0;
    kill_region = active_region;
    if (IRQ_CHECK && irq && (state == FIRST || state == MID || state == LAST)) begin
      go_kill    = 1'b1;
      kill_cause = CAUSE_IRQ;
    end else begin
      case (state)
        IDLE: if (pc_en && any_inreg) begin
          if (first_r[hit_idx]) begin
            next_state = FIRST;
            next_cur   = hit_idx;
          end else begin
            go_kill     = 1'b1;
            kill_cause  = CAUSE_ENTRY;
            kill_region = hit_idx;
          end
        end
        FIRST: if (pc_en) begin
          if (first_cur)       next_state = FIRST;
          else if (mid_cur)    next_state = MID;
          else begin
            go_kill    = 1'b1;
            kill_cause = any_inreg ? CAUSE_ORDER : CAUSE_EXIT;
          end
        end
        MID: if (pc_en) begin
          if (mid_cur)         next_state = MID;
          else if (last_cur)   next_state = LAST;
          else begin
            go_kill    = 1'b1;
            kill_cause = any_inreg ? CAUSE_ORDER : CAUSE_EXIT;
          end
        end
        LAST: if (pc_en) begin
          if (!any_inreg)      next_state = IDLE;
          else if (!last_cur) begin
            go_kill    = 1'b1;
            kill_cause = CAUSE_ORDER;
          end
        end
        KILL: if (pc == RESET_HANDLER) next_state = IDLE;
        default: next_state = KILL;
      endcase
    end
    if (go_kill) next_state = KILL;
  end

  // Outputs are derived from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state         <= KILL;
      reset         <= 1'b1;
      in_region     <= 1'b0;
      active_region <= 2'd0;
      viol_cause    <= 3'd0;
      viol_region   <= 2'd0;
    end else begin
      state         <= next_state;
      reset         <= (next_state == KILL);
      in_region     <= (next_state == FIRST) || (next_state == MID) || (next_state == LAST);
      active_region <= next_cur;
      if (go_kill) begin
        viol_cause  <= kill_cause;
        viol_region <= kill_region;
      end
    end
  end

endmodule
